// File: rtl/bcd_seven_seg_driver_if.sv
// Signal bundle between the lab counter logic (master) and the seven-segment driver (slave).
// conv_state mirrors the converter FSM so checkers can bind to it.
interface bcd_seven_seg_driver_if;
    logic [9:0]  value;
    logic        blank;
    logic [3:0]  sym;
    logic        busy;
    logic [11:0] bcd;
    logic        ovf;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic [1:0]  conv_state;

    modport master (
        output value, blank, sym,
        input  busy, bcd, ovf, DIGIT, DISPLAY, conv_state
    );

    modport slave (
        input  value, blank, sym,
        output busy, bcd, ovf, DIGIT, DISPLAY, conv_state
    );
endinterface

// File: rtl/bcd_seven_seg_driver.sv
// Binary count to 4-digit multiplexed seven-segment display: sequential double-dabble
// converter plus a prescaled scan engine with registered anode/segment outputs.
module bcd_seven_seg_driver #(
    parameter int SCAN_BITS = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_seven_seg_driver_if.slave  bus
);

    // Handshake: busy=1 means a conversion is in flight and value is not sampled;
    // while busy=0 the converter compares the clamped value against the last one
    // converted and starts a new conversion on any difference.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    conv_state_t state;

    logic [9:0]  cv;
    logic        ovf_pending;
    logic [9:0]  last_cv;
    logic [9:0]  sr;
    logic [11:0] acc;
    logic [11:0] acc_adj;
    logic [3:0]  iter;
    logic        ovf_lat;
    logic [11:0] bcd_r;
    logic        ovf_r;
    logic        busy_r;

    always_comb begin
        ovf_pending = (bus.value > 10'd999);
        cv          = ovf_pending ? 10'd999 : bus.value;
    end

    // Add-3 correction applied to every BCD nibble before each shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_cv <= '0;
            sr      <= '0;
            acc     <= '0;
            iter    <= '0;
            ovf_lat <= 1'b0;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cv != last_cv) begin
                        sr      <= cv;
                        acc     <= '0;
                        last_cv <= cv;
                        ovf_lat <= ovf_pending;
                        iter    <= '0;
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= {acc_adj[10:0], sr[9]};
                    sr   <= {sr[8:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd9) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    bcd_r  <= acc;
                    ovf_r  <= ovf_lat;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.bcd        = bcd_r;
    assign bus.ovf        = ovf_r;
    assign bus.conv_state = state;

    function automatic logic [6:0] seg_map(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            4'd10:   seg = 7'b0111111;
            4'd14:   seg = 7'b1011100;
            4'd15:   seg = 7'b1100011;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [SCAN_BITS-1:0] prescaler;
    logic                 tick;
    logic [1:0]           idx;
    logic [1:0]           idx_next;
    logic [3:0]           next_code;
    logic [3:0]           digit_r;
    logic [6:0]           display_r;

    assign tick     = &prescaler;
    assign idx_next = idx + 2'd1;

    // Code for the digit about to be enabled; blank/sym only matter on its tick edge.
    always_comb begin
        case (idx_next)
            2'd0:    next_code = bus.blank ? 4'd10 : bcd_r[3:0];
            2'd1:    next_code = bus.blank ? 4'd10 : bcd_r[7:4];
            2'd2:    next_code = bus.blank ? 4'd10 : bcd_r[11:8];
            default: next_code = bus.sym;
        endcase
    end

    // Anode and segments load on the same edge so they can never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= 2'd0;
            digit_r   <= 4'b1110;
            display_r <= 7'b1111111;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (tick) begin
                idx       <= idx_next;
                digit_r   <= ~(4'b0001 << idx_next);
                display_r <= seg_map(next_code);
            end
        end
    end

    assign bus.DIGIT   = digit_r;
    assign bus.DISPLAY = display_r;

endmodule

// File: tb/tb_bcd_seven_seg_driver.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus directed
// vectors with literal expectations for conversion, clamp, busy overlap, scan and reset.
module tb_bcd_seven_seg_driver;
  localparam int SB = 2;
  localparam int SCAN_PERIOD = 1 << SB;

  logic clk;
  logic rst;
  bcd_seven_seg_driver_if bus ();

  bcd_seven_seg_driver #(.SCAN_BITS(SB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0111111; seg_tab[11] = 7'b1111111;
    seg_tab[12] = 7'b1111111; seg_tab[13] = 7'b1111111; seg_tab[14] = 7'b1011100;
    seg_tab[15] = 7'b1100011;
  end

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  int         m_pre, m_idx, m_left, m_last, m_pend, code;
  bit         m_pend_ovf;
  logic [11:0] m_bcd;
  logic        m_ovf;
  logic [3:0]  m_digit, one_hot;
  logic [6:0]  m_disp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre = 0; m_idx = 0; m_left = 0; m_last = 0; m_pend = 0; m_pend_ovf = 0;
      m_bcd = 12'h000; m_ovf = 1'b0; m_digit = 4'b1110; m_disp = 7'b1111111;
    end else begin
      if ((m_pre % SCAN_PERIOD) == SCAN_PERIOD - 1) begin
        m_idx = (m_idx + 1) % 4;
        one_hot = 4'b0001 << m_idx;
        m_digit = ~one_hot;
        if (m_idx == 3) code = int'(bus.sym);
        else if (bus.blank) code = 10;
        else code = int'((m_bcd >> (4 * m_idx)) & 12'h00f);
        m_disp = seg_tab[code];
      end
      m_pre++;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_bcd = to_bcd(m_pend);
          m_ovf = m_pend_ovf;
        end
      end else begin
        int cv;
        cv = (int'(bus.value) > 999) ? 999 : int'(bus.value);
        if (cv != m_last) begin
          m_last = cv;
          m_pend = cv;
          m_pend_ovf = (int'(bus.value) > 999);
          m_left = 11;
        end
      end
    end
  end

  // scoreboard compare: every cycle outside reset
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      check("bcd", 32'(bus.bcd), 32'(m_bcd));
      check("ovf", 32'(bus.ovf), 32'(m_ovf));
      check("digit", 32'(bus.DIGIT), 32'(m_digit));
      check("display", 32'(bus.DISPLAY), 32'(m_disp));
    end
  end

  // driver tasks
  task automatic set_value(input logic [9:0] v);
    @(negedge clk);
    bus.value = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit"}, 32'(bus.DIGIT), 32'h0000_000e);
    check({tag, "_display"}, 32'(bus.DISPLAY), 32'h0000_007f);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'h0);
    check({tag, "_state"}, 32'(bus.conv_state), 32'h0);
  endtask

  // Waits for busy to rise (if not already) and fall; returns high cycle count.
  task automatic conv_wait(output int cycles);
    int guard;
    cycles = 0;
    guard = 0;
    while (!bus.busy && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    while (bus.busy && cycles < 30) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic wait_digit(input logic [3:0] d, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.DIGIT == d) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  int cyc;
  bit found;
  logic [3:0] seq [4];
  logic [6:0] exp_disp;

  initial begin
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    rst = 1'b0;
    bus.value = 10'd0;
    bus.blank = 1'b0;
    bus.sym = 4'd0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_init");
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // value=0 matches last_cv after reset: no conversion
    repeat (5) @(negedge clk);
    check("idle_no_conv", 32'(bus.busy), 32'h0);

    // conversion of 50
    set_value(10'd50);
    @(negedge clk);
    conv_wait(cyc);
    check("busy_len_50", 32'(cyc), 32'd11);
    check("bcd_50", 32'(bus.bcd), 32'h050);
    check("ovf_50", 32'(bus.ovf), 32'h0);
    repeat (16) @(negedge clk);
    wait_digit(4'b1110, 20, found);
    check("found_d0", 32'(found), 32'h1);
    check("seg_ones_50", 32'(bus.DISPLAY), 32'b1000000);
    wait_digit(4'b1101, 20, found);
    check("found_d1", 32'(found), 32'h1);
    check("seg_tens_50", 32'(bus.DISPLAY), 32'b0010010);

    // clamp
    set_value(10'd1023);
    @(negedge clk);
    conv_wait(cyc);
    check("busy_len_1023", 32'(cyc), 32'd11);
    check("bcd_1023", 32'(bus.bcd), 32'h999);
    check("ovf_1023", 32'(bus.ovf), 32'h1);
    set_value(10'd999);
    cyc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.busy) cyc++;
    end
    check("no_conv_999", 32'(cyc), 32'd0);
    check("ovf_sticky_999", 32'(bus.ovf), 32'h1);
    set_value(10'd998);
    @(negedge clk);
    conv_wait(cyc);
    check("bcd_998", 32'(bus.bcd), 32'h998);
    check("ovf_998", 32'(bus.ovf), 32'h0);

    // value change while busy
    set_value(10'd123);
    repeat (7) @(negedge clk);
    bus.value = 10'd456;
    cyc = 0;
    while (bus.busy && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("bcd_123", 32'(bus.bcd), 32'h123);
    @(negedge clk);
    check("recapture_e12", 32'(bus.busy), 32'h1);
    conv_wait(cyc);
    check("busy_len_456", 32'(cyc), 32'd11);
    check("bcd_456", 32'(bus.bcd), 32'h456);

    // scan order with blank and up symbol
    @(negedge clk);
    bus.blank = 1'b1;
    bus.sym = 4'd14;
    repeat (20) @(negedge clk);
    wait_digit(4'b0111, 20, found);
    check("align_d3", 32'(found), 32'h1);
    wait_digit(4'b1110, 8, found);
    check("align_d0", 32'(found), 32'h1);
    for (int n = 0; n < 16; n++) begin
      exp_disp = (n / 4 == 3) ? 7'b1011100 : 7'b0111111;
      check("scan_digit", 32'(bus.DIGIT), 32'(seq[n / 4]));
      check("scan_display", 32'(bus.DISPLAY), 32'(exp_disp));
      @(negedge clk);
    end
    bus.sym = 4'd12;
    repeat (16) @(negedge clk);
    wait_digit(4'b0111, 20, found);
    check("found_sym12", 32'(found), 32'h1);
    check("seg_sym12", 32'(bus.DISPLAY), 32'b1111111);
    bus.blank = 1'b0;
    bus.sym = 4'd15;

    // reset during SHIFT
    set_value(10'd789);
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("mid_shift_busy", 32'(bus.busy), 32'h1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("bcd_after_rst", 32'(bus.bcd), 32'h0);
    conv_wait(cyc);
    check("busy_len_789", 32'(cyc), 32'd11);
    check("bcd_789", 32'(bus.bcd), 32'h789);
    check("ovf_789", 32'(bus.ovf), 32'h0);
    repeat (20) @(negedge clk);

    // final report
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_seven_seg_driver.md
# bcd_seven_seg_driver

Downstream display stage for the lab counters. Takes a 10-bit binary count plus a leftmost-digit symbol code and drives the 4-digit multiplexed seven-segment display. A sequential double-dabble converter turns the count into three BCD digits without divide/modulo logic. A prescaled scan engine time-multiplexes the digit anodes and the registered segment outputs.

## Interface

- SCAN_BITS, 14: width of the free-running scan prescaler; the scan advances one digit per 2^SCAN_BITS clk cycles.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- value  input  10  binary count to display; values >999 are clamped.
- blank  input  1  1 = digits 0–2 show dash (code 10) instead of BCD.
- sym  input  4  code shown on digit 3 (leftmost); same code set as the digits.
- busy  output  1  converter not IDLE.
- bcd  output  12  last completed conversion, {hundreds, tens, ones}.
- ovf  output  1  last completed conversion was clamped (value >999).
- DIGIT  output  4  anode enables, active-low one-hot, bit0 = rightmost.
- DISPLAY  output  7  segments, active-low, bit6..0 = g..a.

## Operation

- Clamp: cv = (value > 999) ? 999 : value; ovf_pending = (value > 999).
- Converter FSM has three states: IDLE, SHIFT, LATCH.
  - IDLE: if cv != last_cv, capture cv into a 10-bit shift register, clear the 12-bit accumulator, set last_cv = cv, latch ovf_pending, and go to SHIFT with iteration count 0.
  - SHIFT: first, add 3 to each accumulator nibble that is >=5. Then shift {acc, sr} left by 1. Increment the count. After the 10th shift, go to LATCH.
  - LATCH: bcd <= acc, ovf <= latched flag, go to IDLE.
- value changes while busy are ignored. IDLE re-compares against last_cv, so the final settled value is always converted.
- Scan engine:
  - The prescaler increments every clk; tick = (prescaler == all ones).
  - On tick, the digit index advances 0→1→2→3→0.
  - On the same edge, DIGIT and DISPLAY are both loaded for the new index. Anode and segments never change on different edges.
- Digit codes:
  - index 0/1/2 = bcd ones/tens/hundreds, or 10 if blank.
  - index 3 = sym.
- Segment map (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10 (dash)=0111111, 14 (up)=1011100, 15 (down)=1100011
  - 11–13 = 1111111 (off)

## Timing

- Reset values:
  - FSM IDLE; prescaler 0; index 0; last_cv 0.
  - bcd 0; ovf 0; busy 0.
  - DIGIT 4'b1110; DISPLAY 7'b1111111.
- Conversion latency:
  - E0 = the capture edge in IDLE.
  - Shifts occur at E1..E10.
  - bcd/ovf update at E11, returning to IDLE.
  - busy is high from after E0 until E11: exactly 11 cycles.
- Back-to-back conversions: the earliest next capture edge is E12.
- The display reflects a new bcd at the first tick after E11. Digits not yet rescanned keep their old segments until their turn.
- value == last_cv in IDLE: no conversion, busy stays 0.
- Reset mid-conversion: immediate return to the reset values and loss of the partial result. After release, a new conversion starts if cv != 0.
- Scan period: 4·2^SCAN_BITS cycles per full frame. Each digit is enabled exactly 2^SCAN_BITS cycles.
- blank/sym are sampled only on the tick edge that loads their digit.

## Test plan

- Reset: assert rst mid-operation → DIGIT=1110, DISPLAY=1111111, bcd=0, busy=0, ovf=0, all within the same cycle (asynchronous).
- Conversion of 50: hold value=50 after reset → busy for exactly 11 cycles, then bcd=12'h050, ovf=0. With SCAN_BITS=2, the ones digit shows 1000000 and the tens digit shows 0010010.
- Clamp: value=1023 → bcd=12'h999, ovf=1. Then value=999 → no conversion (last_cv matches) and ovf stays 1. Then value=998 → bcd=12'h998, ovf=0.
- Value change while busy:
  - Set 123, then 7 cycles later set 456.
  - Expect bcd=12'h123 at E11.
  - Expect a second capture at E12 and bcd=12'h456 at E12+11.
- Scan order, SCAN_BITS=2:
  - DIGIT steps 1110→1101→1011→0111→1110, one step every 4 cycles.
  - DISPLAY changes only on those edges.
  - With blank=1 and sym=14, digits 0–2 show 0111111 and digit 3 shows 1011100; sym=12 shows 1111111.
- Reset during SHIFT with value=789: after release, bcd=0 until reconversion, then bcd=12'h789.
